// File: rtl/updown_counter_n_pkg.sv
// updown_counter_n_pkg: mode/direction encodings shared by the up/down counter files.
package updown_counter_n_pkg;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // UP/DOWN pin the direction on every edge; BOUNCE/HOLD leave it alone.
    function automatic logic forced_dir(input logic [1:0] mode, input logic dir);
        return (mode == MODE_UP) ? DIR_UP : (mode == MODE_DOWN) ? DIR_DOWN : dir;
    endfunction

endpackage

// File: rtl/udc_next_state.sv
// udc_next_state: combinational one-step successor of (cnt, dir) for an enabled edge.
module udc_next_state
    import updown_counter_n_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_cnt,
    output logic             next_dir,
    output logic             wrap_evt
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam logic             SAT = (SATURATE != 0);

    logic w_at_max;
    logic w_at_zero;

    assign w_at_max  = (cnt == MAX);
    assign w_at_zero = (cnt == '0);

    always_comb begin
        next_cnt = cnt;
        next_dir = forced_dir(mode, dir);
        wrap_evt = 1'b0;
        if (mode == MODE_UP) begin
            next_cnt = w_at_max ? (SAT ? MAX : '0) : cnt + 1'b1;
            wrap_evt = w_at_max && !SAT;
        end else if (mode == MODE_DOWN) begin
            next_cnt = w_at_zero ? (SAT ? '0 : MAX) : cnt - 1'b1;
            wrap_evt = w_at_zero && !SAT;
        end else if (mode == MODE_BOUNCE && dir == DIR_UP) begin
            // Turning at an end steps one back immediately, so ends are never repeated.
            next_cnt = w_at_max ? MAX - 1'b1 : cnt + 1'b1;
            next_dir = w_at_max ? DIR_DOWN : DIR_UP;
            wrap_evt = w_at_max;
        end else if (mode == MODE_BOUNCE) begin
            next_cnt = w_at_zero ? WIDTH'(1) : cnt - 1'b1;
            next_dir = w_at_zero ? DIR_UP : DIR_DOWN;
            wrap_evt = w_at_zero;
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n: parametrised up/down/bounce counter with clear, load, enable and tc/wrap flags.
module updown_counter_n
    import updown_counter_n_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_cnt;
    logic             r_dir;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_cnt;
    logic             w_next_dir;
    logic             w_wrap_evt;
    logic [WIDTH-1:0] w_load_cnt;

    udc_next_state #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .cnt      (r_cnt),
        .dir      (r_dir),
        .mode     (mode),
        .next_cnt (w_next_cnt),
        .next_dir (w_next_dir),
        .wrap_evt (w_wrap_evt)
    );

    assign w_load_cnt = (load_val > MAX) ? MAX : load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dir  <= DIR_UP;
            r_wrap <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_dir  <= DIR_UP;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_cnt  <= w_load_cnt;
            r_dir  <= forced_dir(mode, r_dir);
            r_wrap <= 1'b0;
        end else if (en) begin
            r_cnt  <= w_next_cnt;
            r_dir  <= w_next_dir;
            r_wrap <= w_wrap_evt;
        end else begin
            r_dir  <= forced_dir(mode, r_dir);
            r_wrap <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign dir  = r_dir;
    assign wrap = r_wrap;
    assign tc   = (r_dir == DIR_DOWN) ? (r_cnt == '0) : (r_cnt == MAX);

endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: four counter configurations driven in parallel against an arithmetic reference.
module tb_updown_counter_n;

    localparam int N = 4;
    localparam int MAXV [N] = '{9, 9, 3, 99};
    localparam int SATV [N] = '{0, 1, 0, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;

    logic [7:0] cnt_o  [N];
    logic       dir_o  [N];
    logic       tc_o   [N];
    logic       wrap_o [N];

    int m_cnt [N];
    int m_dir [N];
    int m_wrap[N];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        updown_counter_n #(
            .WIDTH    (8),
            .MAX_VAL  (MAXV[g]),
            .SATURATE (SATV[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .load     (load),
            .load_val (load_val),
            .en       (en),
            .mode     (mode),
            .cnt      (cnt_o[g]),
            .dir      (dir_o[g]),
            .tc       (tc_o[g]),
            .wrap     (wrap_o[g])
        );
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_dir[i] = 0;
            m_wrap[i] = 0;
        end
    endtask

    // Reference: one clock edge applied to every configuration from the written rules.
    task automatic model_edge(input int c, input int l, input int lv, input int e, input int md);
        for (int i = 0; i < N; i++) begin
            int mx, nc, nd, w;
            mx = MAXV[i];
            if (c != 0) begin
                m_cnt[i] = 0;
                m_dir[i] = 0;
                m_wrap[i] = 0;
                continue;
            end
            nc = m_cnt[i];
            nd = (md == 0) ? 0 : (md == 1) ? 1 : m_dir[i];
            w = 0;
            if (l != 0) begin
                nc = (lv < mx) ? lv : mx;
            end else if (e != 0) begin
                if (md == 0) begin
                    if (m_cnt[i] < mx) nc = m_cnt[i] + 1;
                    else if (SATV[i] == 0) begin nc = 0; w = 1; end
                end else if (md == 1) begin
                    if (m_cnt[i] > 0) nc = m_cnt[i] - 1;
                    else if (SATV[i] == 0) begin nc = mx; w = 1; end
                end else if (md == 2) begin
                    if (m_dir[i] == 0) begin
                        if (m_cnt[i] == mx) begin nc = mx - 1; nd = 1; w = 1; end
                        else nc = m_cnt[i] + 1;
                    end else begin
                        if (m_cnt[i] == 0) begin nc = 1; nd = 0; w = 1; end
                        else nc = m_cnt[i] - 1;
                    end
                end
            end
            m_cnt[i] = nc;
            m_dir[i] = nd;
            m_wrap[i] = w;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            int exp_tc;
            exp_tc = (m_dir[i] != 0) ? int'(m_cnt[i] == 0) : int'(m_cnt[i] == MAXV[i]);
            chk($sformatf("%s.cnt%0d", tag, i), int'(cnt_o[i]), m_cnt[i]);
            chk($sformatf("%s.dir%0d", tag, i), int'(dir_o[i]), m_dir[i]);
            chk($sformatf("%s.tc%0d", tag, i), int'(tc_o[i]), exp_tc);
            chk($sformatf("%s.wrap%0d", tag, i), int'(wrap_o[i]), m_wrap[i]);
        end
    endtask

    task automatic step(input string tag, input int c, input int l, input int lv, input int e, input int md);
        clr = 1'(c);
        load = 1'(l);
        load_val = 8'(lv);
        en = 1'(e);
        mode = 2'(md);
        @(posedge clk);
        model_edge(c, l, lv, e, md);
        #1;
        check_all(tag);
    endtask

    initial begin
        int up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int bo_seq [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
        int wraps;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        for (int k = 0; k < 12; k++) begin
            step("up", 0, 0, 0, 1, 0);
            chk("up_seq", int'(cnt_o[0]), up_seq[k]);
            chk("up_wrap", int'(wrap_o[0]), int'(k == 9));
        end
        chk("sat_hold_max", int'(cnt_o[1]), 9);
        chk("sat_tc_max", int'(tc_o[1]), 1);

        step("clr", 1, 0, 0, 1, 0);
        step("down", 0, 0, 0, 1, 1);
        chk("down_wrap_cnt", int'(cnt_o[0]), 9);
        chk("down_wrap", int'(wrap_o[0]), 1);
        chk("sat_down_zero", int'(cnt_o[1]), 0);
        for (int k = 0; k < 11; k++) step("down", 0, 0, 0, 1, 1);
        chk("sat_hold_zero", int'(cnt_o[1]), 0);
        chk("sat_tc_zero", int'(tc_o[1]), 1);

        step("clr", 1, 0, 0, 1, 1);
        wraps = 0;
        for (int k = 0; k < 8; k++) begin
            step("bounce", 0, 0, 0, 1, 2);
            chk("bounce_seq", int'(cnt_o[2]), bo_seq[k]);
            wraps += int'(wrap_o[2]);
        end
        chk("bounce_wraps", wraps, 2);

        step("load_en", 0, 1, 200, 1, 0);
        chk("load_clamp", int'(cnt_o[3]), 99);
        step("clr_load", 1, 1, 50, 1, 0);
        chk("clr_load", int'(cnt_o[3]), 0);
        step("load", 0, 1, 5, 0, 0);
        step("en0", 0, 0, 0, 0, 0);
        chk("en0_frozen", int'(cnt_o[3]), 5);
        step("hold", 0, 0, 0, 1, 3);
        chk("hold_frozen", int'(cnt_o[3]), 5);

        step("load37", 0, 1, 37, 0, 0);
        step("count", 0, 0, 0, 1, 0);
        chk("pre_rst", int'(cnt_o[3]), 38);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_all("rst_release");

        for (int k = 0; k < 400; k++) begin
            step("rand",
                 int'($urandom_range(15) == 0),
                 int'($urandom_range(7) == 0),
                 int'($urandom_range(255)),
                 int'($urandom_range(3) != 0),
                 int'($urandom_range(3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
